// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding shared by the bit-serial subtractor.
package serial_sub_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam int MAX_WIDTH = 64;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } sub_state_t;
endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit subtractor cell computing a - b - bin.
// Ports: a, b, bin in; d (difference), bout (borrow out) out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, with start/busy/done handshake.
// Ports: clk, rst_n (async, active-low); start, a, b in;
//        busy, done (one-cycle pulse), diff, borrow_out (held until next result) out.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);
  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sh_q, sh_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bo_q, busy_q, done_q;
  logic             d, bn, accept, last;
  full_subtractor_bit u_bit (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (br_q),
    .d   (d),
    .bout(bn)
  );
  always_comb begin
    accept  = start && (state_q != SHIFT);
    last    = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    // new bit enters at the MSB so the LSB-first stream ends up in place
    sh_d    = (sh_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
    state_d = accept ? SHIFT : (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d == SHIFT;
      done_q  <= state_d == DONE;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        br_q  <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        sh_q  <= sh_d;
        br_q  <= bn;
        cnt_q <= cnt_q + CW'(1);
        // diff is published only once the last bit has been produced
        if (last) begin
          diff_q <= sh_d;
          bo_q   <= bn;
        end
      end
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH 8 and 1.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       s8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       s1, a1, b1, busy1, done1, diff1, bo1;
  int         errs = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );
  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    a8 = a;
    b8 = b;
    s8 = 1'b1;
    tick();
    s8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin errs++; $display("FAIL start8_busy got %b want 1", busy8); end
  endtask
  task automatic wait_done8(input logic [7:0] ed, input logic eb, input string name);
    int n = 0;
    int bc = 0;
    logic [7:0] prev = diff8;
    logic chg = 1'b0;
    while (!done8 && n < 20) begin
      if (busy8) bc++;
      if (diff8 !== prev) chg = 1'b1;
      tick();
      n++;
    end
    checks += 6;
    if (n != 8) begin errs++; $display("FAIL %s latency got %0d want 8", name, n); end
    if (bc != 8) begin errs++; $display("FAIL %s busy_len got %0d want 8", name, bc); end
    if (chg) begin errs++; $display("FAIL %s diff_changed_in_shift got 1 want 0", name); end
    if (busy8 !== 1'b0) begin errs++; $display("FAIL %s busy_at_done got %b want 0", name, busy8); end
    if (diff8 !== ed) begin errs++; $display("FAIL %s diff got %h want %h", name, diff8, ed); end
    if (bo8 !== eb) begin errs++; $display("FAIL %s borrow got %b want %b", name, bo8, eb); end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    s8 = 1'b0; a8 = '0; b8 = '0;
    s1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    #12;
    checks += 6;
    if (busy8 !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy8); end
    if (done8 !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", done8); end
    if (diff8 !== 8'h00) begin errs++; $display("FAIL rst_diff got %h want 00", diff8); end
    if (bo8 !== 1'b0) begin errs++; $display("FAIL rst_borrow got %b want 0", bo8); end
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin errs++; $display("FAIL rst_w1_flags got %b%b want 00", busy1, done1); end
    if (diff1 !== 1'b0 || bo1 !== 1'b0) begin errs++; $display("FAIL rst_w1_result got %b%b want 00", diff1, bo1); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy8 !== 1'b0) begin errs++; $display("FAIL rst_idle_busy got %b want 0", busy8); end
  endtask
  task automatic test_basic;
    start8(8'h35, 8'h12); wait_done8(8'h23, 1'b0, "35-12");
    tick();
    checks++;
    if (done8 !== 1'b0) begin errs++; $display("FAIL done_one_cycle got %b want 0", done8); end
    start8(8'h12, 8'h35); wait_done8(8'hDD, 1'b1, "12-35");
    tick();
    start8(8'h00, 8'h01); wait_done8(8'hFF, 1'b1, "00-01");
    tick();
    start8(8'hFF, 8'hFF); wait_done8(8'h00, 1'b0, "FF-FF");
    tick(); tick();
    checks += 2;
    if (diff8 !== 8'h00) begin errs++; $display("FAIL idle_hold_diff got %h want 00", diff8); end
    if (done8 !== 1'b0) begin errs++; $display("FAIL idle_done got %b want 0", done8); end
  endtask
  task automatic test_ignore_start;
    int nd = 0;
    start8(8'h35, 8'h12);
    for (int i = 0; i < 15; i++) begin
      if (i == 2) begin s8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
      else s8 = 1'b0;
      tick();
      if (done8) begin
        nd++;
        checks += 3;
        if (i != 7) begin errs++; $display("FAIL ign_done_pos got %0d want 7", i); end
        if (diff8 !== 8'h23) begin errs++; $display("FAIL ign_diff got %h want 23", diff8); end
        if (bo8 !== 1'b0) begin errs++; $display("FAIL ign_borrow got %b want 0", bo8); end
      end
    end
    checks++;
    if (nd != 1) begin errs++; $display("FAIL ign_done_count got %0d want 1", nd); end
  endtask
  task automatic test_back_to_back;
    start8(8'h35, 8'h12); wait_done8(8'h23, 1'b0, "b2b_first");
    a8 = 8'h80; b8 = 8'h01; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    checks += 2;
    if (busy8 !== 1'b1) begin errs++; $display("FAIL b2b_accept_busy got %b want 1", busy8); end
    if (done8 !== 1'b0) begin errs++; $display("FAIL b2b_accept_done got %b want 0", done8); end
    wait_done8(8'h7F, 1'b0, "b2b_second");
    tick();
  endtask
  task automatic test_reset_mid;
    int nd = 0;
    int nb = 0;
    start8(8'h12, 8'h35); wait_done8(8'hDD, 1'b1, "pre_rst");
    tick();
    start8(8'h00, 8'h01);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy8 !== 1'b0) begin errs++; $display("FAIL mid_rst_busy got %b want 0", busy8); end
    if (done8 !== 1'b0) begin errs++; $display("FAIL mid_rst_done got %b want 0", done8); end
    if (diff8 !== 8'h00) begin errs++; $display("FAIL mid_rst_diff got %h want 00", diff8); end
    if (bo8 !== 1'b0) begin errs++; $display("FAIL mid_rst_borrow got %b want 0", bo8); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) nd++;
      if (busy8) nb++;
    end
    checks += 2;
    if (nd != 0) begin errs++; $display("FAIL mid_rst_no_done got %0d want 0", nd); end
    if (nb != 0) begin errs++; $display("FAIL mid_rst_idle got %0d want 0", nb); end
    start8(8'h80, 8'h01); wait_done8(8'h7F, 1'b0, "post_rst");
    tick();
  endtask
  task automatic test_random8;
    logic [7:0] ra, rb;
    logic [8:0] t;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      t = {1'b0, ra} - {1'b0, rb};
      start8(ra, rb);
      wait_done8(t[7:0], t[8], "rand8");
    end
    tick();
  endtask
  task automatic test_random1;
    logic ra, rb;
    logic [1:0] t;
    int n;
    for (int i = 0; i < 1000; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      t = {1'b0, ra} - {1'b0, rb};
      a1 = ra; b1 = rb; s1 = 1'b1;
      tick();
      s1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin tick(); n++; end
      checks += 3;
      if (n != 1) begin errs++; $display("FAIL rand1_latency got %0d want 1", n); end
      if (diff1 !== t[0]) begin errs++; $display("FAIL rand1_diff a=%b b=%b got %b want %b", ra, rb, diff1, t[0]); end
      if (bo1 !== t[1]) begin errs++; $display("FAIL rand1_borrow a=%b b=%b got %b want %b", ra, rb, bo1, t[1]); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_random1();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
